// File: rtl/cpu_types_pkg.sv
// Shared types for the two-core memory/coherence path: RAM handshake,
// controller states and the request classes the arbiter reports.
package cpu_types_pkg;

  localparam int CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, DWB, IFETCH, SNOOP, FWD1, FWD2, LD1, LD2} ccstate_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_WB, CLS_CC, CLS_IF} reqclass_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-core arbiter: highest non-empty request class wins, and a tie inside
// that class goes to the core that was not served last.
module rr_arbiter2
  import cpu_types_pkg::*;
(
  input  logic [1:0] wb_req,
  input  logic [1:0] cc_req,
  input  logic [1:0] if_req,
  input  logic       rr,
  output logic       grant,
  output reqclass_t  req_class
);

  function automatic logic pick(input logic [1:0] v, input logic last);
    return (v == 2'b11) ? ~last : v[1];
  endfunction

  always_comb begin
    req_class = CLS_NONE;
    grant     = 1'b0;
    if (|wb_req) begin
      req_class = CLS_WB;
      grant     = pick(wb_req, rr);
    end else if (|cc_req) begin
      req_class = CLS_CC;
      grant     = pick(cc_req, rr);
    end else if (|if_req) begin
      req_class = CLS_IF;
      grant     = pick(if_req, rr);
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Memory and coherence controller for two cores: arbitrates single-word RAM
// accesses and runs the snoop / cache-to-cache forward sequence on dcache misses.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
)
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic  [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]      iaddr,
  output word_t [CPUS-1:0]      iload,
  output logic  [CPUS-1:0]      iwait,
  input  logic  [CPUS-1:0]      dREN,
  input  logic  [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]      daddr,
  input  word_t [CPUS-1:0]      dstore,
  output word_t [CPUS-1:0]      dload,
  output logic  [CPUS-1:0]      dwait,
  input  logic  [CPUS-1:0]      cctrans,
  input  logic  [CPUS-1:0]      ccwrite,
  output logic  [CPUS-1:0]      ccwait,
  output logic  [CPUS-1:0]      ccinv,
  output word_t [CPUS-1:0]      ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate
);

  ccstate_t  state;
  logic      req;
  logic      rr;
  logic      o;
  logic      access;
  logic      snoop_blocked;
  logic      grant;
  reqclass_t req_class;

  assign o      = ~req;
  assign access = (ramstate == ACCESS);
  // A core that is itself making a coherent miss cannot answer a snoop.
  assign snoop_blocked = cctrans[o] & dREN[o];

  rr_arbiter2 u_arb (
    .wb_req    (dWEN & ~cctrans),
    .cc_req    (cctrans & dREN),
    .if_req    (iREN),
    .rr        (rr),
    .grant     (grant),
    .req_class (req_class)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      req   <= 1'b0;
      rr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req <= grant;
          case (req_class)
            CLS_WB:  state <= DWB;
            CLS_CC:  state <= SNOOP;
            CLS_IF:  state <= IFETCH;
            default: state <= IDLE;
          endcase
        end
        DWB: begin
          if (!dWEN[req]) state <= IDLE;
          else if (access) begin
            rr    <= req;
            state <= IDLE;
          end
        end
        IFETCH: begin
          if (!iREN[req]) state <= IDLE;
          else if (access) begin
            rr    <= req;
            state <= IDLE;
          end
        end
        SNOOP: begin
          if (!(cctrans[req] && dREN[req])) state <= IDLE;
          else if (cctrans[o]) state <= (!snoop_blocked && ccwrite[o]) ? FWD1 : LD1;
        end
        FWD1: if (access) state <= FWD2;
        LD1:  if (access) state <= LD2;
        FWD2, LD2: begin
          if (access) begin
            rr    <= req;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs fall back to their idle values whenever reset is high.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    iload       = '0;
    dload       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (!RST) begin
      case (state)
        DWB: begin
          ramWEN   = dWEN[req];
          ramaddr  = daddr[req];
          ramstore = dstore[req];
          if (dWEN[req] && access) dwait[req] = 1'b0;
        end
        IFETCH: begin
          ramREN     = iREN[req];
          ramaddr    = iaddr[req];
          iload[req] = ramload;
          if (iREN[req] && access) iwait[req] = 1'b0;
        end
        SNOOP: begin
          ccwait[o]      = ~snoop_blocked;
          ccinv[o]       = ~snoop_blocked & ccwrite[req];
          ccsnoopaddr[o] = daddr[req];
        end
        FWD1, FWD2: begin
          ccwait[o]  = 1'b1;
          ramWEN     = 1'b1;
          ramaddr    = daddr[o];
          ramstore   = dstore[o];
          dload[req] = dstore[o];
          if (access) begin
            dwait[req] = 1'b0;
            dwait[o]   = 1'b0;
          end
        end
        LD1, LD2: begin
          ramREN     = 1'b1;
          ramaddr    = daddr[req];
          dload[req] = ramload;
          if (access) dwait[req] = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level model.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  word_t [1:0] iaddr, daddr, dstore;
  word_t [1:0] iload, dload, ccsnoopaddr;
  logic [1:0]  iwait, dwait, ccwait, ccinv;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  int nCompared = 0;
  int nFailed   = 0;

  // Model: what transaction is in flight, who owns it, how far along it is.
  int mKind  = 0;  // 0 none, 1 write-back, 2 fetch, 3 coherent miss
  int mCore  = 0;
  int mStage = 0;  // coherent: 0 snooping, 1 first word, 2 second word
  bit mDirty = 1'b0;
  bit mLast  = 1'b0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pickCore(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 0 : 1;
    return v[1] ? 1 : 0;
  endfunction

  always @(negedge CLK) begin
    logic [1:0]  eIw, eDw, eCw, eCi, wbv, ccv;
    word_t [1:0] eIl, eDl, eSa;
    logic        eRr, eRw;
    word_t       eRa, eRs;
    bit          acc, blocked;
    int          c, o;
    eIw = 2'b11; eDw = 2'b11; eCw = 2'b00; eCi = 2'b00;
    eIl = '0; eDl = '0; eSa = '0;
    eRr = 1'b0; eRw = 1'b0; eRa = '0; eRs = '0;
    acc = (ramstate == ACCESS);
    c = mCore;
    o = 1 - mCore;
    if (RST) begin
      mKind = 0;
      mLast = 1'b0;
    end else begin
      case (mKind)
        1: begin
          eRw = dWEN[c]; eRa = daddr[c]; eRs = dstore[c];
          if (dWEN[c] && acc) eDw[c] = 1'b0;
          if (!dWEN[c]) mKind = 0;
          else if (acc) begin mKind = 0; mLast = (c == 1); end
        end
        2: begin
          eRr = iREN[c]; eRa = iaddr[c]; eIl[c] = ramload;
          if (iREN[c] && acc) eIw[c] = 1'b0;
          if (!iREN[c]) mKind = 0;
          else if (acc) begin mKind = 0; mLast = (c == 1); end
        end
        3: begin
          if (mStage == 0) begin
            blocked = cctrans[o] && dREN[o];
            eCw[o] = !blocked;
            eCi[o] = !blocked && ccwrite[c];
            eSa[o] = daddr[c];
            if (!(cctrans[c] && dREN[c])) mKind = 0;
            else if (cctrans[o]) begin
              mDirty = !blocked && ccwrite[o];
              mStage = 1;
            end
          end else begin
            if (mDirty) begin
              eCw[o] = 1'b1; eRw = 1'b1; eRa = daddr[o]; eRs = dstore[o]; eDl[c] = dstore[o];
              if (acc) begin eDw[c] = 1'b0; eDw[o] = 1'b0; end
            end else begin
              eRr = 1'b1; eRa = daddr[c]; eDl[c] = ramload;
              if (acc) eDw[c] = 1'b0;
            end
            if (acc) begin
              if (mStage == 2) begin mKind = 0; mLast = (c == 1); end
              else mStage = 2;
            end
          end
        end
        default: begin
          wbv = dWEN & ~cctrans;
          ccv = cctrans & dREN;
          if (wbv != 2'b00) begin mKind = 1; mCore = pickCore(wbv, mLast); end
          else if (ccv != 2'b00) begin mKind = 3; mCore = pickCore(ccv, mLast); mStage = 0; end
          else if (iREN != 2'b00) begin mKind = 2; mCore = pickCore(iREN, mLast); end
        end
      endcase
    end
    checkOutput("model_iwait", {30'd0, iwait}, {30'd0, eIw});
    checkOutput("model_dwait", {30'd0, dwait}, {30'd0, eDw});
    checkOutput("model_ccwait", {30'd0, ccwait}, {30'd0, eCw});
    checkOutput("model_ccinv", {30'd0, ccinv}, {30'd0, eCi});
    checkOutput("model_ramREN", {31'd0, ramREN}, {31'd0, eRr});
    checkOutput("model_ramWEN", {31'd0, ramWEN}, {31'd0, eRw});
    checkOutput("model_ram_exclusive", {31'd0, ramREN & ramWEN}, 32'd0);
    checkOutput("model_ramaddr", ramaddr, eRa);
    checkOutput("model_ramstore", ramstore, eRs);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("model_iload%0d", k), iload[k], eIl[k]);
      checkOutput($sformatf("model_dload%0d", k), dload[k], eDl[k]);
      checkOutput($sformatf("model_snoopaddr%0d", k), ccsnoopaddr[k], eSa[k]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic clearInputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic applyStimulus();
    tick();
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(0, 7) == 0) iREN[k]    = ~iREN[k];
      if ($urandom_range(0, 7) == 0) dREN[k]    = ~dREN[k];
      if ($urandom_range(0, 9) == 0) dWEN[k]    = ~dWEN[k];
      if ($urandom_range(0, 5) == 0) cctrans[k] = ~cctrans[k];
      if ($urandom_range(0, 3) == 0) ccwrite[k] = ~ccwrite[k];
      iaddr[k]  = $urandom & 32'hFFFF_FFFC;
      daddr[k]  = $urandom & 32'hFFFF_FFFC;
      dstore[k] = $urandom;
    end
    ramstate = ramstate_t'($urandom_range(0, 3));
    ramload  = $urandom;
    RST      = ($urandom_range(0, 299) == 0);
  endtask

  // Drives core0 store miss against a dirty core1 up to the first FWD cycle.
  task automatic startForward(input ramstate_t fwdState);
    tick();
    cctrans[0] = 1'b1; dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h208; ramstate = BUSY;
    settle();
    checkOutput("fwd_idle_ccwait", {30'd0, ccwait}, 32'd0);
    tick();
    settle();
    checkOutput("fwd_snoop_ccwait", {30'd0, ccwait}, 32'b10);
    checkOutput("fwd_snoop_ccinv", {30'd0, ccinv}, 32'b10);
    checkOutput("fwd_snoop_addr", ccsnoopaddr[1], 32'h208);
    checkOutput("fwd_snoop_dwait", {30'd0, dwait}, 32'b11);
    tick();
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h11;
    settle();
    tick();
    ramstate = fwdState;
    settle();
    checkOutput("fwd1_ramWEN", {31'd0, ramWEN}, 32'd1);
    checkOutput("fwd1_ramaddr", ramaddr, 32'h200);
    checkOutput("fwd1_ramstore", ramstore, 32'h11);
    checkOutput("fwd1_dload0", dload[0], 32'h11);
    checkOutput("fwd1_dwait", {30'd0, dwait}, (fwdState == ACCESS) ? 32'b00 : 32'b11);
  endtask

  initial begin
    int lowCount;
    RST = 1'b1;
    clearInputs();
    settle();
    checkOutput("reset_iwait", {30'd0, iwait}, 32'b11);
    checkOutput("reset_dwait", {30'd0, dwait}, 32'b11);
    checkOutput("reset_ramREN", {31'd0, ramREN}, 32'd0);

    // Single fetch from core0, RAM answers on its second cycle.
    lowCount = 0;
    tick();
    RST = 1'b0; iREN[0] = 1'b1; iaddr[0] = 32'h100; ramstate = BUSY;
    settle();
    checkOutput("fetch_arb_ramREN", {31'd0, ramREN}, 32'd0);
    if (!iwait[0]) lowCount++;
    tick();
    settle();
    checkOutput("fetch_ramREN", {31'd0, ramREN}, 32'd1);
    checkOutput("fetch_ramaddr", ramaddr, 32'h100);
    if (!iwait[0]) lowCount++;
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    checkOutput("fetch_iload0", iload[0], 32'hDEADBEEF);
    checkOutput("fetch_iwait", {30'd0, iwait}, 32'b10);
    if (!iwait[0]) lowCount++;
    tick();
    clearInputs();
    settle();
    if (!iwait[0]) lowCount++;
    checkOutput("fetch_iwait_low_cycles", lowCount, 32'd1);

    // Core0 store miss, core1 supplies its dirty line.
    startForward(ACCESS);
    tick();
    daddr[1] = 32'h204; dstore[1] = 32'h22; ramstate = BUSY;
    settle();
    checkOutput("fwd2_busy_dwait", {30'd0, dwait}, 32'b11);
    checkOutput("fwd2_busy_ramWEN", {31'd0, ramWEN}, 32'd1);
    tick();
    ramstate = ACCESS;
    settle();
    checkOutput("fwd2_ramaddr", ramaddr, 32'h204);
    checkOutput("fwd2_ramstore", ramstore, 32'h22);
    checkOutput("fwd2_dload0", dload[0], 32'h22);
    checkOutput("fwd2_dwait", {30'd0, dwait}, 32'b00);
    tick();
    clearInputs();
    settle();
    checkOutput("fwd_done_ramWEN", {31'd0, ramWEN}, 32'd0);

    // Reset pulse while forwarding.
    startForward(BUSY);
    tick();
    RST = 1'b1;
    settle();
    checkOutput("rst_fwd_iwait", {30'd0, iwait}, 32'b11);
    checkOutput("rst_fwd_dwait", {30'd0, dwait}, 32'b11);
    checkOutput("rst_fwd_ramWEN", {31'd0, ramWEN}, 32'd0);
    checkOutput("rst_fwd_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("rst_fwd_ccwait", {30'd0, ccwait}, 32'd0);
    tick();
    RST = 1'b0;
    clearInputs();
    settle();
    checkOutput("rst_release_ccwait", {30'd0, ccwait}, 32'd0);

    // Core1 eviction beats core0 coherent read miss; core1 answers clean.
    tick();
    dWEN[1] = 1'b1; daddr[1] = 32'h300; dstore[1] = 32'hABC;
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h400; ramstate = BUSY;
    settle();
    tick();
    ramstate = ACCESS;
    settle();
    checkOutput("evict_ramWEN", {31'd0, ramWEN}, 32'd1);
    checkOutput("evict_ramaddr", ramaddr, 32'h300);
    checkOutput("evict_ramstore", ramstore, 32'hABC);
    checkOutput("evict_dwait", {30'd0, dwait}, 32'b01);
    checkOutput("evict_ccwait", {30'd0, ccwait}, 32'd0);
    tick();
    dWEN[1] = 1'b0; daddr[1] = '0; dstore[1] = '0; ramstate = BUSY;
    settle();
    tick();
    settle();
    checkOutput("clean_snoop_ccwait", {30'd0, ccwait}, 32'b10);
    checkOutput("clean_snoop_ccinv", {30'd0, ccinv}, 32'd0);
    checkOutput("clean_snoop_addr", ccsnoopaddr[1], 32'h400);
    tick();
    cctrans[1] = 1'b1;
    settle();
    tick();
    ramstate = ACCESS; ramload = 32'h5555;
    settle();
    checkOutput("ld1_ramREN", {31'd0, ramREN}, 32'd1);
    checkOutput("ld1_ramaddr", ramaddr, 32'h400);
    checkOutput("ld1_dload0", dload[0], 32'h5555);
    checkOutput("ld1_dwait", {30'd0, dwait}, 32'b10);
    checkOutput("ld1_ccwait", {30'd0, ccwait}, 32'd0);
    tick();
    daddr[0] = 32'h404; ramload = 32'h6666;
    settle();
    checkOutput("ld2_ramaddr", ramaddr, 32'h404);
    checkOutput("ld2_dload0", dload[0], 32'h6666);
    checkOutput("ld2_dwait", {30'd0, dwait}, 32'b10);
    tick();
    clearInputs();
    settle();

    // Both cores fetch continuously: grants alternate, core1 first (core0 served last).
    tick();
    iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20; ramstate = ACCESS;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k % 2 == 0) begin
        checkOutput($sformatf("rr_arb%0d_ramREN", k), {31'd0, ramREN}, 32'd0);
      end else begin
        checkOutput($sformatf("rr_grant%0d_ramaddr", k), ramaddr, (k == 3) ? 32'h10 : 32'h20);
        checkOutput($sformatf("rr_grant%0d_iwait", k), {30'd0, iwait}, (k == 3) ? 32'b10 : 32'b01);
      end
      tick();
    end
    clearInputs();

    for (int n = 0; n < 3000; n++) applyStimulus();
    tick();
    RST = 1'b0;
    settle();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
